risc_controller: RTL and testbench

Eight-phase instruction sequencer for the 8-bit RISC core. It steps a phase register through fetch and execute phases and decodes the current phase, the 3-bit instruction opcode and the accumulator-zero flag from the ALU into the control strobes for the core. Those strobes drive the program counter, instruction register, accumulator, memory and data bus. It sits beside the datapath. It takes `opcode` from the instruction register and `zero` from the ALU's accumulator-zero output.

---
 rtl/risc_pkg.sv | 35 +++
 rtl/risc_ctrl_decode.sv | 71 +++++++
 rtl/risc_controller.sv | 67 ++++++
 tb/tb_risc_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes (also used by the ALU),
// sequencer phase encoding and widths.
package risc_pkg;

  localparam int unsigned PHASE_WIDTH   = 3;
  localparam int unsigned OP_CODE_WIDTH = 3;

  typedef logic [OP_CODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_HLT = 3'd0;
  localparam opcode_t OP_SKZ = 3'd1;
  localparam opcode_t OP_ADD = 3'd2;
  localparam opcode_t OP_AND = 3'd3;
  localparam opcode_t OP_XOR = 3'd4;
  localparam opcode_t OP_LDA = 3'd5;
  localparam opcode_t OP_STO = 3'd6;
  localparam opcode_t OP_JMP = 3'd7;

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational phase/opcode/zero to control-strobe decode; all strobes are
// suppressed once the core has halted.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  phase_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    ld_ac,
  output logic    wr,
  output logic    data_e
);

  logic aluop;
  logic op_skz;
  logic op_sto;
  logic op_jmp;

  always_comb begin
    aluop  = is_aluop(opcode);
    op_skz = (opcode == OP_SKZ);
    op_sto = (opcode == OP_STO);
    op_jmp = (opcode == OP_JMP);

    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;

    if (!halted) begin
      unique case (phase)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: inc_pc = 1'b1;
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = op_skz & zero;
          ld_pc  = op_jmp;
          data_e = op_sto;
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = op_jmp;
          data_e = op_sto;
          wr     = op_sto;
        end
      endcase
    end
  end

endmodule

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer: phase counter with memory wait states,
// sticky halt flag, and strobe decode for the RISC datapath.
module risc_controller #(
  parameter int unsigned PHASE_WIDTH   = 3,
  parameter int unsigned OP_CODE_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OP_CODE_WIDTH-1:0] opcode,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     sel,
  output logic                     rd,
  output logic                     ld_ir,
  output logic                     inc_pc,
  output logic                     ld_pc,
  output logic                     ld_ac,
  output logic                     wr,
  output logic                     data_e,
  output logic                     halt,
  output logic [PHASE_WIDTH-1:0]   phase
);

  import risc_pkg::*;

  phase_t phase_q;
  logic   halted;
  logic   stall;

  // Only the memory-read phases wait for read data.
  always_comb begin
    stall = !mem_ready &&
            ((phase_q == INST_FETCH) || ((phase_q == OP_FETCH) && is_aluop(opcode)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
      halted  <= 1'b0;
    end else if (!halted) begin
      if ((phase_q == OP_ADDR) && (opcode == OP_HLT)) begin
        halted <= 1'b1;
      end else if (!stall) begin
        phase_q <= phase_t'(phase_q + 1'b1);
      end
    end
  end

  risc_ctrl_decode u_decode (
    .phase  (phase_q),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e)
  );

  assign halt  = halted;
  assign phase = phase_q;

endmodule

// File: tb/tb_risc_controller.sv
// Directed self-checking bench for risc_controller.
// Strobe vector bit order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
module tb_risc_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic [8:0] strobes;

  int checks   = 0;
  int failures = 0;

  risc_controller #(.PHASE_WIDTH(3), .OP_CODE_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .data_e    (data_e),
    .halt      (halt),
    .phase     (phase)
  );

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench just after a falling edge with the DUT in INST_ADDR.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (strobes !== 9'b100000000 || phase !== 3'd0) begin
      failures++;
      $display("FAIL reset: phase=%0d strobes=%b expected phase=0 strobes=100000000", phase, strobes);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [8:0] exp [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                            9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    do_reset();
    opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (strobes !== exp[i % 8] || phase !== 3'(i % 8)) begin
        failures++;
        $display("FAIL add c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 i, phase, strobes, i % 8, exp[i % 8]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skz();
    logic [8:0] exp [8];
    for (int z = 0; z < 2; z++) begin
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
      if (z == 1) exp[6] = 9'b000100000;
      do_reset();
      opcode = 3'd1; zero = 1'(z); mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        #1;
        checks++;
        if (strobes !== exp[i] || phase !== 3'(i)) begin
          failures++;
          $display("FAIL skz z=%0d c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                   z, i, phase, strobes, i, exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  // mem_ready is held low after INST_FETCH: a non-ALU opcode must not stall in OP_FETCH.
  task automatic test_jmp();
    logic [8:0] exp [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                            9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000};
    do_reset();
    opcode = 3'd7; zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i <= 1);
      #1;
      checks++;
      if (strobes !== exp[i] || phase !== 3'(i)) begin
        failures++;
        $display("FAIL jmp c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 i, phase, strobes, i, exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_sto();
    logic [8:0] exp [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    do_reset();
    opcode = 3'd6; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (strobes !== exp[i] || phase !== 3'(i)) begin
        failures++;
        $display("FAIL sto c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 i, phase, strobes, i, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic       mr  [15] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic [2:0] ph  [15] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 5, 5, 5, 6, 7, 0};
    logic [8:0] exp [15] = '{9'b100000000, 9'b110000000, 9'b110000000, 9'b110000000,
                             9'b110000000, 9'b111000000, 9'b111000000, 9'b000100000,
                             9'b010000000, 9'b010000000, 9'b010000000, 9'b010000000,
                             9'b010000000, 9'b010001000, 9'b100000000};
    do_reset();
    opcode = 3'd5; zero = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (strobes !== exp[i] || phase !== ph[i]) begin
        failures++;
        $display("FAIL stall c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 i, phase, strobes, ph[i], exp[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_halt();
    logic [8:0] exp [5] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                            9'b000100000};
    do_reset();
    opcode = 3'd0; zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (strobes !== exp[i] || phase !== 3'(i)) begin
        failures++;
        $display("FAIL halt_pre c%0d: phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 i, phase, strobes, i, exp[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode    = (i >= 10) ? 3'd2 : 3'd0;
      #1;
      checks++;
      if (strobes !== 9'b000000001 || phase !== 3'd4) begin
        failures++;
        $display("FAIL halted c%0d: phase=%0d strobes=%b expected phase=4 strobes=000000001",
                 i, phase, strobes);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (strobes !== 9'b100000000 || phase !== 3'd0) begin
      failures++;
      $display("FAIL halt_async_reset: phase=%0d strobes=%b expected phase=0 strobes=100000000",
               phase, strobes);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (strobes !== 9'b110000000 || phase !== 3'd1) begin
      failures++;
      $display("FAIL halt_restart: phase=%0d strobes=%b expected phase=1 strobes=110000000",
               phase, strobes);
    end
  endtask

  task automatic test_reset_mid_sto();
    do_reset();
    opcode = 3'd6; zero = 1'b0; mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (strobes !== 9'b000000010 || phase !== 3'd6) begin
      failures++;
      $display("FAIL sto_pre_reset: phase=%0d strobes=%b expected phase=6 strobes=000000010",
               phase, strobes);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (strobes !== 9'b100000000 || phase !== 3'd0) begin
      failures++;
      $display("FAIL sto_async_reset: phase=%0d strobes=%b expected phase=0 strobes=100000000",
               phase, strobes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (strobes !== 9'b100000000 || phase !== 3'd0) begin
      failures++;
      $display("FAIL sto_released: phase=%0d strobes=%b expected phase=0 strobes=100000000",
               phase, strobes);
    end
    @(negedge clk);
    #1;
    checks++;
    if (strobes !== 9'b110000000 || phase !== 3'd1) begin
      failures++;
      $display("FAIL sto_next_instr: phase=%0d strobes=%b expected phase=1 strobes=110000000",
               phase, strobes);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_skz();
    test_jmp();
    test_sto();
    test_stall();
    test_halt();
    test_reset_mid_sto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
